hazard_ctrl: RTL and testbench

- Central stall/bubble/forwarding controller for the 5-stage MIPS pipeline (fetch, decode, execute, memory, writeback).
- Drives the `execute_enable` input of the execute stage. Low means execute latches a zero bubble on the next clk.
- Freezes the pipeline during multi-cycle data-memory accesses and redirects fetch on taken branches/jumps.
- Keeps a stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, bubble and forwarding control for the 5-stage MIPS pipeline.
// Pipeline control outputs are combinational decisions for the current cycle and
// are forced low while reset is high; the stall counter and timeout flag are registered.
module hazard_ctrl #(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [REG_AW-1:0] ex_wa,
   input  logic              ex_mem_to_reg,
   input  logic              ex_branch_taken,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_wa,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_wa,
   input  logic              dmem_req,
   input  logic              dmem_ack,
   output logic              fetch_en,
   output logic              decode_en,
   output logic              execute_enable,
   output logic              ex_hold,
   output logic              mem_hold,
   output logic              pc_redirect,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic              mem_error
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_LU_STALL = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   logic              err_set;
   logic              lu_hit;
   logic              mem_busy;

   // Hazard detection terms; register 0 never creates a dependency.
   assign lu_hit   = ex_mem_to_reg & id_valid & (ex_wa != '0) &
                     ((ex_wa == id_rs) | (ex_wa == id_rt));
   assign mem_busy = dmem_req & ~dmem_ack;

   // State and memory-wait counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next-state and pipeline control decode.
   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = wait_cnt;
      err_set        = 1'b0;
      fetch_en       = 1'b1;
      decode_en      = 1'b1;
      execute_enable = 1'b1;
      ex_hold        = 1'b0;
      mem_hold       = 1'b0;
      pc_redirect    = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_busy) begin
               fetch_en     = 1'b0;
               decode_en    = 1'b0;
               ex_hold      = 1'b1;
               mem_hold     = 1'b1;
               state_nxt    = ST_MEM_WAIT;
               wait_cnt_nxt = WAIT_W'(1);
            end else if (lu_hit) begin
               fetch_en       = 1'b0;
               decode_en      = 1'b0;
               execute_enable = 1'b0;
               state_nxt      = ST_LU_STALL;
            end else if (ex_branch_taken) begin
               pc_redirect = 1'b1;
            end
         end
         ST_LU_STALL: begin
            // The load is in memory now; forwarding covers the dependency.
            if (mem_busy) begin
               fetch_en     = 1'b0;
               decode_en    = 1'b0;
               ex_hold      = 1'b1;
               mem_hold     = 1'b1;
               state_nxt    = ST_MEM_WAIT;
               wait_cnt_nxt = WAIT_W'(1);
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            // Ack or timeout releases the freeze in the same cycle; a pending
            // branch stays presented by the held execute stage and fires in RUN.
            if (dmem_ack) begin
               state_nxt = ST_RUN;
            end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
               err_set   = 1'b1;
               state_nxt = ST_RUN;
            end else begin
               fetch_en     = 1'b0;
               decode_en    = 1'b0;
               ex_hold      = 1'b1;
               mem_hold     = 1'b1;
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
      if (reset) begin
         fetch_en       = 1'b0;
         decode_en      = 1'b0;
         execute_enable = 1'b0;
         ex_hold        = 1'b0;
         mem_hold       = 1'b0;
         pc_redirect    = 1'b0;
      end
   end

   // ALU operand forwarding, MEM stage has priority over WB.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (mem_reg_write && (mem_wa != '0) && (mem_wa == ex_rs)) begin
         fwd_a = FWD_MEM;
      end else if (wb_reg_write && (wb_wa != '0) && (wb_wa == ex_rs)) begin
         fwd_a = FWD_WB;
      end
      if (mem_reg_write && (mem_wa != '0) && (mem_wa == ex_rt)) begin
         fwd_b = FWD_MEM;
      end else if (wb_reg_write && (wb_wa != '0) && (wb_wa == ex_rt)) begin
         fwd_b = FWD_WB;
      end
      if (reset) begin
         fwd_a = FWD_RF;
         fwd_b = FWD_RF;
      end
   end

   // Saturating stall counter and sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         mem_error    <= 1'b0;
      end else begin
         if (!fetch_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (err_set) begin
            mem_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences,
// expected outputs queued at drive time and compared on the falling edge.
module tb_hazard_ctrl;

   localparam int unsigned AW  = 5;
   localparam int unsigned TMO = 4;
   localparam int unsigned CW  = 4;

   typedef struct packed {
      logic          id_valid;
      logic [AW-1:0] id_rs;
      logic [AW-1:0] id_rt;
      logic [AW-1:0] ex_rs;
      logic [AW-1:0] ex_rt;
      logic [AW-1:0] ex_wa;
      logic          ex_mem_to_reg;
      logic          ex_branch_taken;
      logic          mem_reg_write;
      logic [AW-1:0] mem_wa;
      logic          wb_reg_write;
      logic [AW-1:0] wb_wa;
      logic          dmem_req;
      logic          dmem_ack;
   } in_t;

   typedef struct {
      in_t         i;
      logic [10:0] e;
      string       nm;
   } vec_t;

   // Expected output word: {fetch_en, decode_en, execute_enable, ex_hold,
   // mem_hold, pc_redirect, fwd_a, fwd_b, mem_error}
   localparam logic [10:0] E_RUN = 11'b111_000_00_00_0;
   localparam logic [10:0] E_FRZ = 11'b001_110_00_00_0;
   localparam logic [10:0] E_LU  = 11'b000_000_00_00_0;
   localparam logic [10:0] E_BR  = 11'b111_001_00_00_0;

   logic          clk = 1'b0;
   logic          reset;
   in_t           cur;
   logic          fetch_en, decode_en, execute_enable, ex_hold, mem_hold, pc_redirect;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_cycles;
   logic          mem_error;
   logic [10:0]   act;

   logic [10:0]   exp_q[$];
   string         name_q[$];
   vec_t          tbl[$];
   logic [CW-1:0] stall_m;
   int            n_chk = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   assign act = {fetch_en, decode_en, execute_enable, ex_hold, mem_hold,
                 pc_redirect, fwd_a, fwd_b, mem_error};

   hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_valid        (cur.id_valid),
      .id_rs           (cur.id_rs),
      .id_rt           (cur.id_rt),
      .ex_rs           (cur.ex_rs),
      .ex_rt           (cur.ex_rt),
      .ex_wa           (cur.ex_wa),
      .ex_mem_to_reg   (cur.ex_mem_to_reg),
      .ex_branch_taken (cur.ex_branch_taken),
      .mem_reg_write   (cur.mem_reg_write),
      .mem_wa          (cur.mem_wa),
      .wb_reg_write    (cur.wb_reg_write),
      .wb_wa           (cur.wb_wa),
      .dmem_req        (cur.dmem_req),
      .dmem_ack        (cur.dmem_ack),
      .fetch_en        (fetch_en),
      .decode_en       (decode_en),
      .execute_enable  (execute_enable),
      .ex_hold         (ex_hold),
      .mem_hold        (mem_hold),
      .pc_redirect     (pc_redirect),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b),
      .stall_cycles    (stall_cycles),
      .mem_error       (mem_error)
   );

   task automatic add(input in_t v, input logic [10:0] e, input string nm);
      vec_t r;
      r.i  = v;
      r.e  = e;
      r.nm = nm;
      tbl.push_back(r);
   endtask

   // Pop the expected word for this cycle and compare, then advance the stall model.
   task automatic check_out();
      logic [10:0] e;
      string       nm;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %b with nothing expected", act);
      end else begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, e);
         end
         n_chk++;
         if (stall_cycles !== stall_m) begin
            n_fail++;
            $display("FAIL %s_stall: got %0d expected %0d", nm, stall_cycles, stall_m);
         end
         if (!e[10] && (stall_m != '1)) stall_m = stall_m + CW'(1);
      end
   endtask

   task automatic step(input in_t v, input logic [10:0] e, input string nm);
      @(posedge clk);
      #1;
      cur = v;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      check_out();
   endtask

   // Called just after a falling edge; reset takes effect immediately.
   task automatic do_reset(input string nm);
      cur   = '0;
      reset = 1'b1;
      #2;
      n_chk++;
      if (act !== 11'b0) begin
         n_fail++;
         $display("FAIL %s_outputs: got %b expected %b", nm, act, 11'b0);
      end
      n_chk++;
      if (stall_cycles !== '0) begin
         n_fail++;
         $display("FAIL %s_stall: got %0d expected 0", nm, stall_cycles);
      end
      reset   = 1'b0;
      stall_m = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_t v;
      cur     = '0;
      reset   = 1'b1;
      stall_m = '0;

      v = '0;                                                           add(v, E_RUN, "idle");
      v = '0; v.mem_reg_write = 1; v.mem_wa = 9; v.wb_reg_write = 1; v.wb_wa = 9;
      v.ex_rs = 9; v.ex_rt = 9;                                         add(v, 11'b111_000_10_10_0, "fwd_mem_prio");
      v.mem_reg_write = 0;                                              add(v, 11'b111_000_01_01_0, "fwd_wb");
      v.mem_reg_write = 1; v.mem_wa = 0; v.wb_wa = 0; v.ex_rs = 0; v.ex_rt = 0;
                                                                        add(v, E_RUN, "fwd_reg0");
      v = '0; v.mem_reg_write = 1; v.mem_wa = 3; v.wb_reg_write = 1; v.wb_wa = 7;
      v.ex_rs = 7; v.ex_rt = 3;                                         add(v, 11'b111_000_01_10_0, "fwd_mixed");
      v = '0; v.mem_wa = 9; v.wb_wa = 9; v.ex_rs = 9; v.ex_rt = 9;      add(v, E_RUN, "fwd_no_we");
      v = '0; v.ex_mem_to_reg = 1; v.id_valid = 1;                      add(v, E_RUN, "lu_reg0");
      v = '0; v.ex_mem_to_reg = 1; v.ex_wa = 8; v.id_rs = 8;            add(v, E_RUN, "lu_not_valid");
      v.id_valid = 1; v.id_rs = 7; v.id_rt = 6;                         add(v, E_RUN, "lu_mismatch");
      v = '0; v.id_valid = 1; v.ex_wa = 8; v.id_rs = 8;                 add(v, E_RUN, "lu_not_load");
      v = '0; v.ex_branch_taken = 1;                                    add(v, E_BR,  "branch");
      v = '0; v.dmem_req = 1; v.dmem_ack = 1;                           add(v, E_RUN, "req_ack_same");
      v = '0; v.ex_branch_taken = 1; v.mem_reg_write = 1; v.mem_wa = 5; v.ex_rt = 5;
                                                                        add(v, 11'b111_001_00_10_0, "branch_fwd");

      @(negedge clk);
      do_reset("reset_initial");

      foreach (tbl[k]) step(tbl[k].i, tbl[k].e, tbl[k].nm);

      // Load-use bubble, then one LU_STALL cycle with the hazard still presented.
      @(negedge clk);
      do_reset("reset_lu");
      v = '0; v.ex_mem_to_reg = 1; v.ex_wa = 8; v.id_rs = 8; v.id_valid = 1;
      step(v, E_LU, "lu_bubble");
      step(v, E_RUN, "lu_stall_cycle");
      v = '0;
      step(v, E_RUN, "lu_done");
      v = '0; v.ex_mem_to_reg = 1; v.ex_wa = 12; v.id_rt = 12; v.id_valid = 1; v.ex_branch_taken = 1;
      step(v, E_LU, "lu_over_branch");
      v = '0;
      step(v, E_RUN, "lu_rt_stall");
      v = '0; v.dmem_req = 1; v.ex_mem_to_reg = 1; v.ex_wa = 8; v.id_rs = 8; v.id_valid = 1;
      step(v, E_FRZ, "mem_over_lu");
      v = '0; v.dmem_req = 1; v.dmem_ack = 1;
      step(v, E_RUN, "mem_over_lu_ack");
      v = '0;
      step(v, E_RUN, "mem_over_lu_done");

      // Memory stall released by an ack three cycles after the request.
      @(negedge clk);
      do_reset("reset_mem");
      v = '0; v.dmem_req = 1;
      step(v, E_FRZ, "mem_wait0");
      v.mem_reg_write = 1; v.mem_wa = 4; v.ex_rs = 4;
      step(v, 11'b001_110_10_00_0, "fwd_in_wait");
      v = '0; v.dmem_req = 1;
      step(v, E_FRZ, "mem_wait2");
      v.dmem_ack = 1;
      step(v, E_RUN, "mem_ack_release");
      v = '0;
      step(v, E_RUN, "mem_done");
      n_chk++;
      if (stall_cycles !== CW'(3)) begin
         n_fail++;
         $display("FAIL mem_stall_total: got %0d expected 3", stall_cycles);
      end

      // Branch presented during MEM_WAIT is deferred to the first RUN cycle.
      @(negedge clk);
      do_reset("reset_br");
      v = '0; v.dmem_req = 1;
      step(v, E_FRZ, "br_wait0");
      v.ex_branch_taken = 1;
      step(v, E_FRZ, "br_deferred");
      v.dmem_ack = 1;
      step(v, E_RUN, "br_ack_cycle");
      v = '0; v.ex_branch_taken = 1;
      step(v, E_BR, "br_first_run");
      v = '0;
      step(v, E_RUN, "br_done");

      // Timeout after TMO wait cycles, sticky error, then reset mid-stall.
      @(negedge clk);
      do_reset("reset_tmo");
      v = '0; v.dmem_req = 1;
      for (int j = 0; j < 4; j++) step(v, E_FRZ, $sformatf("tmo_wait%0d", j));
      step(v, E_RUN, "timeout_release");
      v = '0;
      step(v, E_RUN | 11'd1, "mem_error_sticky");
      v.dmem_req = 1;
      step(v, E_FRZ | 11'd1, "err_wait0");
      step(v, E_FRZ | 11'd1, "err_wait1");
      do_reset("reset_mid_stall");
      v = '0;
      step(v, E_RUN, "post_reset_run");

      // Repeated timeouts under a stuck request drive the counter into saturation.
      @(negedge clk);
      do_reset("reset_sat");
      v = '0; v.dmem_req = 1;
      for (int j = 0; j < 25; j++) begin
         step(v, ((j % 5 == 4) ? E_RUN : E_FRZ) | {10'd0, (j >= 5)}, $sformatf("sat%0d", j));
      end
      v = '0;
      step(v, E_RUN | 11'd1, "sat_done");
      n_chk++;
      if (stall_cycles !== '1) begin
         n_fail++;
         $display("FAIL stall_saturate: got %0d expected %0d", stall_cycles, {CW{1'b1}});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
